// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default receive-buffer depth and the
// per-edge operation decode used by the receive FIFO.
package uart_pkg;

   localparam int UART_DATA_W        = 8;
   localparam int UART_RX_FIFO_DEPTH = 8;

   // What the buffer does on a given edge once push/pop qualification is known.
   typedef enum logic [1:0] {
      FIFO_IDLE = 2'b00,
      FIFO_PUSH = 2'b01,
      FIFO_POP  = 2'b10,
      FIFO_BOTH = 2'b11
   } fifo_op_e;

   function automatic fifo_op_e fifo_op(input logic push, input logic pop);
      fifo_op_e op;
      case ({pop, push})
         2'b01:   op = FIFO_PUSH;
         2'b10:   op = FIFO_POP;
         2'b11:   op = FIFO_BOTH;
         default: op = FIFO_IDLE;
      endcase
      return op;
   endfunction

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO: one synchronous write port and a
// registered read port. The array itself is never reset so it can map to RAM.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = UART_RX_FIFO_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Only the output register is reset; a read that coincides with a write to
   // the same slot returns the old contents, which is the byte being popped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: captures each received
// byte, holds up to DEPTH of them for the host and flags bytes lost while full.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = UART_RX_FIFO_DEPTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_W-1:0]         rx_data,
   input  logic                      rx_valid,
   input  logic                      rd_en,
   input  logic                      clr_ovf,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      rd_valid,
   output logic                      empty,
   output logic                      full,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   // Handshake: rx_valid is a one-cycle strobe with no back-pressure (a byte
   // offered while full with no pop is dropped and flagged); rd_en is a pop
   // request honoured only when not empty, answered by a one-cycle rd_valid
   // pulse the following cycle with rd_data held until the next pop.

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q,  count_d;
   logic              overflow_q, overflow_d;
   logic              rd_valid_q, rd_valid_d;

   logic     empty_w;
   logic     full_w;
   logic     do_pop;
   logic     do_push;
   logic     do_drop;
   fifo_op_e op;

   // Flags come from the occupancy count; pointer equality alone is ambiguous.
   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == CNT_FULL);

   assign do_pop  = rd_en && !empty_w;
   assign do_push = rx_valid && (!full_w || do_pop);
   assign do_drop = rx_valid && full_w && !do_pop;
   assign op      = fifo_op(do_push, do_pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_valid_d = do_pop;

      // Power-of-two depth: the pointer increment wraps DEPTH-1 -> 0 naturally.
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      case (op)
         FIFO_PUSH: count_d = count_q + CNT_ONE;
         FIFO_POP:  count_d = count_q - CNT_ONE;
         default:   count_d = count_q;
      endcase
   end

   // A drop on the same edge as a clear wins, so no lost byte goes unreported.
   always_comb begin
      overflow_d = overflow_q;
      if (do_drop) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   uart_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .rst     (reset),
      .we_i    (do_push),
      .waddr_i (wr_ptr_q),
      .wdata_i (rx_data),
      .re_i    (do_pop),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
   );

   assign rd_valid = rd_valid_q;
   assign empty    = empty_w;
   assign full     = full_w;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule : uart_rx_fifo
